word_bitwise_checker: RTL and testbench
=======================================

Name: word_bitwise_checker

Overview:
- Receive-side checker for the 8-bit word-bitwise datapath.
- Captures the three operand words driven into the mixer and recomputes the expected word through a LAT-deep delay line.
- Compares each expected word against the mixer's __out0 stream, counts matches and mismatches, and raises a sticky fail flag.
- Sits beside the mixer in regression and FPGA self-test builds.

Parameters:
- LAT, 1, cycles from operand sample to the corresponding mixer output; legal range 1..8.
- CNT_W, 16, width of the match and mismatch counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  operands valid this cycle; stream enable.
- __in0  input  8  operand a, the same value driven to the mixer.
- __in1  input  8  operand b.
- __in2  input  8  operand c.
- dut_out  input  8  mixer __out0.
- clear  input  1  synchronous clear of counters, flag and pipeline.
- match_cnt  output  CNT_W  compared-equal count, saturating.
- miss_cnt  output  CNT_W  compared-unequal count, saturating.
- fail  output  1  sticky; set on the first mismatch.
- busy  output  1  state != IDLE.

Behaviour:
- Expected function: f(a,b,c) = ((a & b) ^ c) | ~((~a & ~b) ^ c), bitwise over 8 bits, no width growth.
- Pipeline: LAT-stage shift register of {valid, f(a,b,c)}.
  - Stage 0 loads {en, f(__in0,__in1,__in2)} every cycle.
  - Stage LAT-1 is the compare stage.
- Compare: on a cycle where the compare-stage valid = 1 and state is RUN:
  - expected == dut_out: match_cnt++.
  - expected != dut_out: miss_cnt++ and fail <= 1.
  - When the compare-stage valid = 0, nothing is counted.
- Counters saturate at 2^CNT_W-1 and never wrap.
- FSM:
  - IDLE: en=1 -> FILL; the fill counter loads LAT-1.
  - FILL: the counter decrements every cycle. At 0 -> RUN, and the compare stage is compared in that same cycle. Stream gaps (en=0) during FILL still advance the counter; invalid stages are skipped.
  - RUN: compares each cycle. When no valid entry remains in the pipeline and en=0 -> IDLE.
  - fail does not change state; the checker keeps counting after a failure.
- clear=1 (synchronous, highest priority after rst):
  - Zeroes counters, fail and all pipeline valids; state -> IDLE.
  - en in the same cycle is ignored.
- rst=0 at any time, including mid-stream: all outputs 0, pipeline valids 0, state IDLE, asynchronously. Release is sampled on the next rising clk.
- Reset values: match_cnt=0, miss_cnt=0, fail=0, busy=0.
- Simultaneous events:
  - Mismatch and saturation together: fail still sets and miss_cnt holds its maximum.
  - clear and mismatch together: clear wins.

Optional Feature:
- Macro: WORD_CHECK_CAPTURE_EN.
- When defined, adds these outputs:
  - cap_exp [7:0] and cap_got [7:0]: expected and dut_out of the first mismatch.
  - cap_idx [CNT_W-1:0]: the value of match_cnt+miss_cnt at that mismatch.
- The capture registers load only while fail=0 and hold afterwards. They reset to 0 on rst=0 or clear.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- LAT=1, drive a=0x0F, b=0x3C, c=0x55 with en=1, then dut_out=0x7B one cycle later -> match_cnt=1, miss_cnt=0, fail=0.
- LAT=1, operand vectors (0x00,0x00,0x00), (0xFF,0xFF,0xFF), (0xFF,0x00,0x00) in consecutive cycles, with dut_out 0x00, 0x00, 0xFF -> match_cnt=3, busy returns to 0 after the stream ends.
- Same stream but with dut_out 0x01 on the second word -> miss_cnt=1, fail=1, match_cnt=2. With WORD_CHECK_CAPTURE_EN: cap_exp=0x00, cap_got=0x01, cap_idx=1.
- LAT=3, stream of 5 words with a one-cycle en gap -> no compare in the first 2 cycles, exactly 5 compares, gap cycle not counted.
- CNT_W=4, 20 matching words -> match_cnt stays at 0xF. Then assert clear -> all counters 0, busy=0 next cycle.
- Assert rst=0 mid-stream, with fail=1 and miss_cnt=2 -> immediately all outputs 0. After release, a new matching word gives match_cnt=1.

Source files
------------

// File: rtl/word_bitwise_checker.sv
// -----------------------------------------------------------------------------
// word_bitwise_checker
//
// Receive-side checker for the 8-bit word-bitwise mixer. The three operand
// words driven into the mixer are captured here, the expected word
//   f(a,b,c) = ((a & b) ^ c) | ~((~a & ~b) ^ c)
// is recomputed and carried through a LAT-deep delay line, and the value
// leaving the delay line is compared against the mixer output. Matches and
// mismatches are counted (saturating) and a sticky fail flag is raised on
// the first mismatch.
//
// Parameters
//   LAT    cycles from operand sample to the matching mixer output (1..8)
//   CNT_W  width of the match / mismatch counters
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   en         operands valid this cycle
//   __in0..2   operands a, b, c (same values the mixer sees)
//   dut_out    mixer output word under test
//   clear      synchronous clear of counters, flag, pipeline and FSM
//   match_cnt  saturating count of equal compares
//   miss_cnt   saturating count of unequal compares
//   fail       sticky, set on the first mismatch
//   busy       FSM is not in IDLE
//
// Optional build macro WORD_CHECK_CAPTURE_EN adds:
//   cap_exp    expected word of the first mismatch
//   cap_got    dut_out of the first mismatch
//   cap_idx    match_cnt + miss_cnt at the moment of the first mismatch
//
// Handshake: en is a qualifier only (no ready). A word is accepted on every
// rising edge where en=1 and clear=0; the checker never stalls the stream.
// -----------------------------------------------------------------------------
module word_bitwise_checker #(
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       __in0,
  input  logic [7:0]       __in1,
  input  logic [7:0]       __in2,
  input  logic [7:0]       dut_out,
  input  logic             clear,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             fail,
  output logic             busy
`ifdef WORD_CHECK_CAPTURE_EN
  ,
  output logic [7:0]       cap_exp,
  output logic [7:0]       cap_got,
  output logic [CNT_W-1:0] cap_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t       state;
  logic [2:0]   fill_cnt;
  logic [LAT-1:0] vld;
  logic [7:0]   exp_pipe [LAT];

  logic [7:0]   f_in;
  logic         pending;
  logic         cmp_v;
  logic         cmp_hit;

  // Expected word for the operands presented this cycle.
  assign f_in = ((__in0 & __in1) ^ __in2) | ~((~__in0 & ~__in1) ^ __in2);

  // Anything still to be compared after this cycle: the incoming word or any
  // stage ahead of the compare stage. The compare stage itself is consumed
  // in the current cycle, so it does not hold the FSM in RUN.
  always_comb begin
    pending = en;
    for (int i = 0; i < LAT - 1; i++) begin
      pending = pending | vld[i];
    end
  end

  // The last FILL cycle (counter at zero) already lines up with the first
  // valid word reaching the compare stage, so it compares like RUN does.
  assign cmp_v   = vld[LAT-1] &&
                   ((state == RUN) || ((state == FILL) && (fill_cnt == 3'd0)));
  assign cmp_hit = (exp_pipe[LAT-1] == dut_out);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fill_cnt  <= 3'd0;
      vld       <= '0;
      for (int i = 0; i < LAT; i++) begin
        exp_pipe[i] <= 8'h00;
      end
      match_cnt <= '0;
      miss_cnt  <= '0;
      fail      <= 1'b0;
`ifdef WORD_CHECK_CAPTURE_EN
      cap_exp   <= 8'h00;
      cap_got   <= 8'h00;
      cap_idx   <= '0;
`endif
    end else if (clear) begin
      // en in the same cycle is dropped: stage 0 valid is forced low too.
      state     <= IDLE;
      fill_cnt  <= 3'd0;
      vld       <= '0;
      for (int i = 0; i < LAT; i++) begin
        exp_pipe[i] <= 8'h00;
      end
      match_cnt <= '0;
      miss_cnt  <= '0;
      fail      <= 1'b0;
`ifdef WORD_CHECK_CAPTURE_EN
      cap_exp   <= 8'h00;
      cap_got   <= 8'h00;
      cap_idx   <= '0;
`endif
    end else begin
      // Delay line: stage 0 loads every cycle, higher stages shift.
      vld[0]      <= en;
      exp_pipe[0] <= f_in;
      for (int i = 1; i < LAT; i++) begin
        vld[i]      <= vld[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (en) begin
            state    <= FILL;
            fill_cnt <= 3'(LAT - 1);
          end
        end
        FILL: begin
          // Gaps in the stream do not pause the countdown.
          if (fill_cnt == 3'd0) begin
            state <= RUN;
          end else begin
            fill_cnt <= fill_cnt - 3'd1;
          end
        end
        RUN: begin
          if (!pending) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (cmp_v) begin
        if (cmp_hit) begin
          if (match_cnt != CNT_MAX) begin
            match_cnt <= match_cnt + 1'b1;
          end
        end else begin
          if (miss_cnt != CNT_MAX) begin
            miss_cnt <= miss_cnt + 1'b1;
          end
          fail <= 1'b1;
`ifdef WORD_CHECK_CAPTURE_EN
          // Only the first mismatch is recorded; later ones leave it alone.
          if (!fail) begin
            cap_exp <= exp_pipe[LAT-1];
            cap_got <= dut_out;
            cap_idx <= match_cnt + miss_cnt;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_word_bitwise_checker.sv
// -----------------------------------------------------------------------------
// tb_word_bitwise_checker
//
// Two checker instances: u0 (LAT=1, CNT_W=16) and u1 (LAT=3, CNT_W=4).
// For every accepted word the bench decides the mixer output it will present
// LAT cycles later and updates a count-level reference model at that moment
// (compares happen in acceptance order, so totals after draining agree).
// Cycles with no scheduled word drive random junk on dut_out, which must
// never be counted.
// -----------------------------------------------------------------------------
module tb_word_bitwise_checker;

  localparam int LAT0 = 1;
  localparam int CW0  = 16;
  localparam int LAT1 = 3;
  localparam int CW1  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // stimulus per instance
  logic       en_s    [2];
  logic [7:0] a_s     [2];
  logic [7:0] b_s     [2];
  logic [7:0] c_s     [2];
  logic [7:0] out_s   [2];
  logic       clear_s [2];

  logic [CW0-1:0] match0, miss0;
  logic           fail0, busy0;
  logic [CW1-1:0] match1, miss1;
  logic           fail1, busy1;
`ifdef WORD_CHECK_CAPTURE_EN
  logic [7:0]     cexp0, cgot0, cexp1, cgot1;
  logic [CW0-1:0] cidx0;
  logic [CW1-1:0] cidx1;
`endif

  word_bitwise_checker #(.LAT(LAT0), .CNT_W(CW0)) u0 (
    .clk(clk), .rst(rst), .en(en_s[0]),
    .__in0(a_s[0]), .__in1(b_s[0]), .__in2(c_s[0]),
    .dut_out(out_s[0]), .clear(clear_s[0]),
    .match_cnt(match0), .miss_cnt(miss0), .fail(fail0), .busy(busy0)
`ifdef WORD_CHECK_CAPTURE_EN
    , .cap_exp(cexp0), .cap_got(cgot0), .cap_idx(cidx0)
`endif
  );

  word_bitwise_checker #(.LAT(LAT1), .CNT_W(CW1)) u1 (
    .clk(clk), .rst(rst), .en(en_s[1]),
    .__in0(a_s[1]), .__in1(b_s[1]), .__in2(c_s[1]),
    .dut_out(out_s[1]), .clear(clear_s[1]),
    .match_cnt(match1), .miss_cnt(miss1), .fail(fail1), .busy(busy1)
`ifdef WORD_CHECK_CAPTURE_EN
    , .cap_exp(cexp1), .cap_got(cgot1), .cap_idx(cidx1)
`endif
  );

  // reference model state
  int         m_match [2];
  int         m_miss  [2];
  bit         m_fail  [2];
  logic [7:0] m_cexp  [2];
  logic [7:0] m_cgot  [2];
  int         m_cidx  [2];

  // mixer-output schedule, indexed by cycle modulo 32
  logic [7:0] sched_d [2][32];
  bit         sched_v [2][32];
  int         cyc;

  int checks;
  int failures;

  logic [7:0] ra, rb, rc, rf, rg;

  function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return ((a & b) ^ c) | ~((~a & ~b) ^ c);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
  endfunction

  function automatic logic [31:0] obs_match(input int k);
    return (k == 0) ? 32'(match0) : 32'(match1);
  endfunction
  function automatic logic [31:0] obs_miss(input int k);
    return (k == 0) ? 32'(miss0) : 32'(miss1);
  endfunction
  function automatic logic [31:0] obs_fail(input int k);
    return (k == 0) ? 32'(fail0) : 32'(fail1);
  endfunction
  function automatic logic [31:0] obs_busy(input int k);
    return (k == 0) ? 32'(busy0) : 32'(busy1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input int k, input string tag, input logic exp_busy);
    chk({tag, "_match"}, obs_match(k), 32'(m_match[k]));
    chk({tag, "_miss"},  obs_miss(k),  32'(m_miss[k]));
    chk({tag, "_fail"},  obs_fail(k),  32'(m_fail[k]));
    chk({tag, "_busy"},  obs_busy(k),  32'(exp_busy));
`ifdef WORD_CHECK_CAPTURE_EN
    chk({tag, "_cap_exp"}, (k == 0) ? 32'(cexp0) : 32'(cexp1), 32'(m_cexp[k]));
    chk({tag, "_cap_got"}, (k == 0) ? 32'(cgot0) : 32'(cgot1), 32'(m_cgot[k]));
    chk({tag, "_cap_idx"}, (k == 0) ? 32'(cidx0) : 32'(cidx1), 32'(m_cidx[k]));
`endif
  endtask

  task automatic m_reset(input int k);
    m_match[k] = 0;
    m_miss[k]  = 0;
    m_fail[k]  = 1'b0;
    m_cexp[k]  = 8'h00;
    m_cgot[k]  = 8'h00;
    m_cidx[k]  = 0;
    for (int s = 0; s < 32; s++) sched_v[k][s] = 1'b0;
  endtask

  // driver: default inputs for the cycle about to start
  task automatic begin_cycle();
    for (int k = 0; k < 2; k++) begin
      int slot;
      slot = cyc % 32;
      out_s[k]   = sched_v[k][slot] ? sched_d[k][slot] : 8'($urandom);
      sched_v[k][slot] = 1'b0;
      en_s[k]    = 1'b0;
      a_s[k]     = 8'($urandom);
      b_s[k]     = 8'($urandom);
      c_s[k]     = 8'($urandom);
      clear_s[k] = 1'b0;
    end
  endtask

  // driver: present one word and the mixer output it will produce
  task automatic put(input int k, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] got);
    logic [7:0] f;
    int slot;
    en_s[k] = 1'b1;
    a_s[k]  = a;
    b_s[k]  = b;
    c_s[k]  = c;
    f = ref_f(a, b, c);
    slot = (cyc + lat_of(k)) % 32;
    sched_d[k][slot] = got;
    sched_v[k][slot] = 1'b1;
    if (got == f) begin
      if (m_match[k] < cmax(k)) m_match[k]++;
    end else begin
      if (!m_fail[k]) begin
        m_cexp[k] = f;
        m_cgot[k] = got;
        m_cidx[k] = (m_match[k] + m_miss[k]) & cmax(k);
      end
      if (m_miss[k] < cmax(k)) m_miss[k]++;
      m_fail[k] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      begin_cycle();
      tick();
    end
  endtask

  // clear with en raised in the same cycle; that word must be dropped
  task automatic do_clear(input int k);
    begin_cycle();
    clear_s[k] = 1'b1;
    en_s[k]    = 1'b1;
    tick();
    m_reset(k);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_reset(0);
    m_reset(1);

    // ---- reset ----
    rst = 1'b0;
    begin_cycle();
    tick();
    tick();
    chk_all(0, "reset0", 1'b0);
    chk_all(1, "reset1", 1'b0);
    rst = 1'b1;
    idle(2);
    chk_all(0, "idle_junk0", 1'b0);

    // ---- single matching word, LAT=1 ----
    begin_cycle();
    put(0, 8'h0F, 8'h3C, 8'h55, 8'h7B);
    tick();
    idle(3);
    chk_all(0, "t1", 1'b0);
    chk("t1_match_const", obs_match(0), 32'd1);

    // ---- three-word stream, all matching ----
    do_clear(0);
    chk_all(0, "t2_clr", 1'b0);
    begin_cycle(); put(0, 8'h00, 8'h00, 8'h00, 8'h00); tick();
    chk("t2_busy", obs_busy(0), 32'd1);
    begin_cycle(); put(0, 8'hFF, 8'hFF, 8'hFF, 8'h00); tick();
    begin_cycle(); put(0, 8'hFF, 8'h00, 8'h00, 8'hFF); tick();
    idle(4);
    chk_all(0, "t2", 1'b0);
    chk("t2_match_const", obs_match(0), 32'd3);

    // ---- same stream, second word wrong ----
    do_clear(0);
    begin_cycle(); put(0, 8'h00, 8'h00, 8'h00, 8'h00); tick();
    begin_cycle(); put(0, 8'hFF, 8'hFF, 8'hFF, 8'h01); tick();
    begin_cycle(); put(0, 8'hFF, 8'h00, 8'h00, 8'hFF); tick();
    idle(4);
    chk_all(0, "t3", 1'b0);
    chk("t3_miss_const", obs_miss(0), 32'd1);
`ifdef WORD_CHECK_CAPTURE_EN
    chk("t3_cap_idx_const", 32'(cidx0), 32'd1);
`endif

    // ---- LAT=3, five words with a one-cycle gap ----
    do_clear(1);
    chk_all(1, "t4_clr", 1'b0);
    idle(4);
    chk("t4_clr_en_dropped", obs_match(1), 32'd0);
    begin_cycle(); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
    put(1, ra, rb, rc, ref_f(ra, rb, rc)); tick();
    begin_cycle(); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
    put(1, ra, rb, rc, ref_f(ra, rb, rc)); tick();
    chk("t4_nocmp1", obs_match(1), 32'd0);
    begin_cycle(); tick();  // gap
    chk("t4_nocmp2", obs_match(1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      put(1, ra, rb, rc, ref_f(ra, rb, rc)); tick();
      if (i == 0) chk("t4_first_cmp", obs_match(1), 32'd1);
    end
    idle(6);
    chk_all(1, "t4", 1'b0);
    chk("t4_match_const", obs_match(1), 32'd5);

    // ---- CNT_W=4 saturation ----
    do_clear(1);
    for (int i = 0; i < 20; i++) begin
      begin_cycle(); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      put(1, ra, rb, rc, ref_f(ra, rb, rc)); tick();
    end
    idle(6);
    chk_all(1, "t5_sat", 1'b0);
    chk("t5_sat_const", obs_match(1), 32'h0F);
    for (int i = 0; i < 17; i++) begin
      begin_cycle(); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      rf = ref_f(ra, rb, rc);
      put(1, ra, rb, rc, rf ^ 8'($urandom_range(1, 255))); tick();
    end
    idle(6);
    chk_all(1, "t5_miss_sat", 1'b0);
    // clear while mismatching words are in flight and one is at compare
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      put(1, ra, rb, rc, ~ref_f(ra, rb, rc)); tick();
    end
    do_clear(1);
    chk_all(1, "t5_clear", 1'b0);
    idle(6);
    chk_all(1, "t5_post_clear", 1'b0);

    // ---- randomized traffic on both instances ----
    do_clear(0);
    do_clear(1);
    for (int n = 0; n < 400; n++) begin
      begin_cycle();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 9) < 7) begin
          ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
          rf = ref_f(ra, rb, rc);
          rg = ($urandom_range(0, 29) == 0) ? (rf ^ 8'($urandom_range(1, 255))) : rf;
          put(k, ra, rb, rc, rg);
        end
      end
      tick();
    end
    idle(8);
    chk_all(0, "rand0", 1'b0);
    chk_all(1, "rand1", 1'b0);

    // ---- asynchronous reset mid-stream ----
    do_clear(0);
    begin_cycle(); put(0, 8'h12, 8'h34, 8'h56, ~ref_f(8'h12, 8'h34, 8'h56)); tick();
    begin_cycle(); put(0, 8'hA5, 8'h5A, 8'h3C, ~ref_f(8'hA5, 8'h5A, 8'h3C)); tick();
    begin_cycle(); put(0, 8'h0F, 8'h3C, 8'h55, 8'h7B); tick();
    chk("t6_pre_miss", obs_miss(0), 32'd2);
    chk("t6_pre_fail", obs_fail(0), 32'd1);
    #1;
    rst = 1'b0;
    #2;
    m_reset(0);
    m_reset(1);
    chk_all(0, "t6_async", 1'b0);
    chk_all(1, "t6_async1", 1'b0);
    tick();
    rst = 1'b1;
    begin_cycle();
    put(0, 8'h0F, 8'h3C, 8'h55, 8'h7B);
    tick();
    idle(3);
    chk_all(0, "t6_after", 1'b0);
    chk("t6_after_const", obs_match(0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
